// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the term-project CPU.
// Holds default widths, the EX/MEM register state enum, and the EX/MEM
// control bundle together with its all-zero bubble value.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  // RUN: memory ready, register advances. HOLD: memory busy, register frozen.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } exmem_state_t;

  // Control fields carried from EX into MEM.
  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } exmem_ctrl_t;

  // A bubble carries no side effects.
  localparam exmem_ctrl_t EXMEM_BUBBLE = '{valid: 1'b0, mem_read: 1'b0,
                                           mem_write: 1'b0, reg_write: 1'b0};

  // An invalid EX instruction must never write memory or registers,
  // so every control bit is qualified by the valid flag.
  function automatic exmem_ctrl_t qualify_ctrl(
    input logic valid,
    input logic mem_read,
    input logic mem_write,
    input logic reg_write
  );
    exmem_ctrl_t c;
    c.valid     = valid;
    c.mem_read  = valid & mem_read;
    c.mem_write = valid & mem_write;
    c.reg_write = valid & reg_write;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones,
// cleared by synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: advance only while below the saturation point.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register.
// Captures execute-stage results every ready cycle, loads a bubble on a
// load-use stall or branch flush, and freezes while data memory is busy.
// A flush that arrives during a freeze is remembered and applied on the
// first ready edge.
// Optional feature: define EXMEM_STATS_EN to add saturating stall and
// bubble counters (parameter CNT_W, ports stall_count/bubble_count).
module ex_mem_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
`ifdef EXMEM_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_reg_op1,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              EXMEMValid,
  output logic              EXMEMMemRead,
  output logic              EXMEMMemWrite,
  output logic              EXMEMRegWrite,
  output logic [REG_W-1:0]  EXMEMRegOp1,
  output logic [DATA_W-1:0] EXMEMAluResult,
  output logic [DATA_W-1:0] EXMEMStoreData,
  output logic              ex_hold
`ifdef EXMEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
`endif
);

  // ---------------------------------------------------------------------
  // RUN/HOLD tracking (informational; the datapath keys off mem_ready)
  // ---------------------------------------------------------------------
  exmem_state_t state_q;
  exmem_state_t state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: follow memory readiness from either state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!mem_ready) state_d = HOLD;
      HOLD:    if (mem_ready)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Freeze request to upstream stages has zero latency from mem_ready.
  always_comb begin
    ex_hold = !mem_ready;
  end

  // ---------------------------------------------------------------------
  // Pipeline register datapath
  // ---------------------------------------------------------------------
  exmem_ctrl_t       ctrl_q,       ctrl_d;
  logic [REG_W-1:0]  reg_op1_q,    reg_op1_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic              flush_pending_q, flush_pending_d;
  logic              load_bubble;

  // A bubble replaces the capture only on edges where memory lets us move;
  // stall and flush together still produce exactly one bubble.
  assign load_bubble = mem_ready & (flush | flush_pending_q | stall);

  // Next register contents: hold, bubble, or capture, in that priority.
  always_comb begin
    ctrl_d          = ctrl_q;
    reg_op1_d       = reg_op1_q;
    alu_result_d    = alu_result_q;
    store_data_d    = store_data_q;
    flush_pending_d = flush_pending_q;
    if (!mem_ready) begin
      // Frozen: remember a flush so it is not lost; stall is dropped since
      // the hazard unit re-evaluates once the hold ends.
      flush_pending_d = flush_pending_q | flush;
    end else if (load_bubble) begin
      ctrl_d          = EXMEM_BUBBLE;
      reg_op1_d       = '0;
      alu_result_d    = '0;
      store_data_d    = '0;
      flush_pending_d = 1'b0;
    end else begin
      ctrl_d          = qualify_ctrl(ex_valid, ex_mem_read, ex_mem_write, ex_reg_write);
      reg_op1_d       = ex_reg_op1;
      alu_result_d    = ex_alu_result;
      store_data_d    = ex_store_data;
      flush_pending_d = 1'b0;
    end
  end

  // Pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q          <= EXMEM_BUBBLE;
      reg_op1_q       <= '0;
      alu_result_q    <= '0;
      store_data_q    <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      ctrl_q          <= ctrl_d;
      reg_op1_q       <= reg_op1_d;
      alu_result_q    <= alu_result_d;
      store_data_q    <= store_data_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign EXMEMValid     = ctrl_q.valid;
  assign EXMEMMemRead   = ctrl_q.mem_read;
  assign EXMEMMemWrite  = ctrl_q.mem_write;
  assign EXMEMRegWrite  = ctrl_q.reg_write;
  assign EXMEMRegOp1    = reg_op1_q;
  assign EXMEMAluResult = alu_result_q;
  assign EXMEMStoreData = store_data_q;

`ifdef EXMEM_STATS_EN
  // ---------------------------------------------------------------------
  // Statistics: stalls are counted only when they can act (memory ready).
  // ---------------------------------------------------------------------
  logic stall_inc;
  assign stall_inc = stall & mem_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (load_bubble),
    .count (bubble_count)
  );
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the register.
// Counters are checked when EXMEM_STATS_EN is defined (small CNT_W so that
// saturation is reachable quickly).
module tb_ex_mem_stage_reg;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, stall_drv, flush, mem_ready, ex_valid;
  logic          ex_mem_read, ex_mem_write, ex_reg_write;
  logic [RW-1:0] ex_reg_op1;
  logic [DW-1:0] ex_alu_result, ex_store_data;
  logic          EXMEMValid, EXMEMMemRead, EXMEMMemWrite, EXMEMRegWrite;
  logic [RW-1:0] EXMEMRegOp1;
  logic [DW-1:0] EXMEMAluResult, EXMEMStoreData;
  logic          ex_hold;
  logic          stall;
`ifdef EXMEM_STATS_EN
  logic [TB_CNT_W-1:0] stall_count, bubble_count;
`endif

  // Minimal hazard-detection stand-in: load in MEM whose destination
  // matches a source operand of the instruction in ID/EX.
  logic          hz_mode;
  logic [RW-1:0] IDEXRegOp1, IDEXRegOp2;
  logic          IDEXImmd;
  logic          hz_stall;
  assign hz_stall = EXMEMMemRead &&
                    ((IDEXRegOp1 == EXMEMRegOp1) ||
                     (!IDEXImmd && (IDEXRegOp2 == EXMEMRegOp1)));
  assign stall = hz_mode ? hz_stall : stall_drv;

  ex_mem_stage_reg #(
    .DATA_W(DW),
    .REG_W (RW)
`ifdef EXMEM_STATS_EN
    ,
    .CNT_W (TB_CNT_W)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_ready      (mem_ready),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_reg_op1     (ex_reg_op1),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .EXMEMValid     (EXMEMValid),
    .EXMEMMemRead   (EXMEMMemRead),
    .EXMEMMemWrite  (EXMEMMemWrite),
    .EXMEMRegWrite  (EXMEMRegWrite),
    .EXMEMRegOp1    (EXMEMRegOp1),
    .EXMEMAluResult (EXMEMAluResult),
    .EXMEMStoreData (EXMEMStoreData),
    .ex_hold        (ex_hold)
`ifdef EXMEM_STATS_EN
    ,
    .stall_count    (stall_count),
    .bubble_count   (bubble_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid, m_mr, m_mw, m_rw, m_pend, m_hold;
  bit [RW-1:0] m_rd;
  bit [DW-1:0] m_alu, m_sd;
  int          m_sc, m_bc;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // What one rising edge does, stated directly from the priority rules.
  task automatic model_edge();
    if (reset) begin
      {m_valid, m_mr, m_mw, m_rw, m_pend, m_hold} = '0;
      m_rd = '0; m_alu = '0; m_sd = '0; m_sc = 0; m_bc = 0;
    end else if (!mem_ready) begin
      m_hold = 1;
      if (flush) m_pend = 1;
    end else begin
      m_hold = 0;
      if (stall) m_sc = sat_inc(m_sc);
      if (flush || m_pend || stall) begin
        {m_valid, m_mr, m_mw, m_rw, m_pend} = '0;
        m_rd = '0; m_alu = '0; m_sd = '0;
        m_bc = sat_inc(m_bc);
      end else begin
        m_valid = ex_valid;
        m_mr = ex_valid && ex_mem_read;
        m_mw = ex_valid && ex_mem_write;
        m_rw = ex_valid && ex_reg_write;
        m_rd = ex_reg_op1; m_alu = ex_alu_result; m_sd = ex_store_data;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},  32'(EXMEMValid),     32'(m_valid));
    check({tag, ".mrd"},    32'(EXMEMMemRead),   32'(m_mr));
    check({tag, ".mwr"},    32'(EXMEMMemWrite),  32'(m_mw));
    check({tag, ".rwr"},    32'(EXMEMRegWrite),  32'(m_rw));
    check({tag, ".rd"},     32'(EXMEMRegOp1),    32'(m_rd));
    check({tag, ".alu"},    32'(EXMEMAluResult), 32'(m_alu));
    check({tag, ".sd"},     32'(EXMEMStoreData), 32'(m_sd));
    check({tag, ".state"},  32'(dut.state_q),    32'(m_hold));
    check({tag, ".ex_hold"}, 32'(ex_hold),       32'(!mem_ready));
`ifdef EXMEM_STATS_EN
    check({tag, ".stall_cnt"},  32'(stall_count),  32'(m_sc));
    check({tag, ".bubble_cnt"}, 32'(bubble_count), 32'(m_bc));
`endif
  endtask

  // One clock: ex_hold is checked combinationally before the edge, then the
  // model advances and all outputs are compared 1ns after the edge.
  task automatic tick(input string tag);
    #1;
    check({tag, ".hold_comb"}, 32'(ex_hold), 32'(!mem_ready));
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic rand_ex();
    ex_valid      = ($urandom_range(0, 3) != 0);
    ex_mem_read   = $urandom_range(0, 1);
    ex_mem_write  = $urandom_range(0, 1);
    ex_reg_write  = $urandom_range(0, 1);
    ex_reg_op1    = RW'($urandom);
    ex_alu_result = DW'($urandom);
    ex_store_data = DW'($urandom);
  endtask

  task automatic set_ex(input bit v, input bit mr, input bit mw, input bit rw,
                        input int rd, input int alu, input int sd);
    ex_valid = v; ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw;
    ex_reg_op1 = RW'(rd); ex_alu_result = DW'(alu); ex_store_data = DW'(sd);
  endtask

  initial begin
    int bc0;
    int sc0;
    logic [DW-1:0] frozen_alu;
    hz_mode = 0; IDEXRegOp1 = '0; IDEXRegOp2 = '0; IDEXImmd = 1'b0;
    reset = 1; stall_drv = 1; flush = 1; mem_ready = 1;
    set_ex(1, 1, 1, 1, 7, 'h1234, 'h5678);

    // Reset with nonzero inputs for two edges.
    tick("reset0");
    tick("reset1");
    reset = 0; stall_drv = 0; flush = 0;

    // Normal capture.
    set_ex(1, 0, 0, 1, 3, 'h00A5, 'h0011);
    tick("capture");
    check("capture.rd3", 32'(EXMEMRegOp1), 32'd3);
    check("capture.a5",  32'(EXMEMAluResult), 32'h00A5);

    // ex_valid=0 suppresses all control.
    set_ex(0, 1, 1, 1, 9, 'h0F0F, 'hF0F0);
    tick("invalid");

    // Load-use via the hazard stand-in.
    set_ex(1, 1, 0, 1, 5, 'h0040, 'h0000);
    tick("load");
    hz_mode = 1; IDEXRegOp1 = 4'd1; IDEXRegOp2 = 4'd5; IDEXImmd = 1'b0;
    set_ex(1, 0, 0, 1, 6, 'h0002, 'h0000);
    bc0 = m_bc;
    #1;
    check("loaduse.stall_on", 32'(stall), 32'd1);
    tick("loaduse.bubble");
    check("loaduse.stall_off", 32'(stall), 32'd0);
    check("loaduse.mrd0", 32'(EXMEMMemRead), 32'd0);
    check("loaduse.bubbles", 32'(m_bc - bc0), 32'd1);
    tick("loaduse.resume");
    hz_mode = 0;

    // Memory hold for three cycles with changing inputs.
    frozen_alu = EXMEMAluResult;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      stall_drv = $urandom_range(0, 1);
      tick("memhold");
      check("memhold.frozen", 32'(EXMEMAluResult), 32'(frozen_alu));
    end
    mem_ready = 1; stall_drv = 0;
    set_ex(1, 0, 1, 0, 2, 'hBEEF, 'hCAFE);
    tick("memhold.resume");

    // Flush pulse during a hold is applied on the first ready edge.
    mem_ready = 0; flush = 1; rand_ex();
    tick("flushhold.pulse");
    flush = 0; rand_ex();
    tick("flushhold.wait");
    mem_ready = 1; set_ex(1, 0, 0, 1, 4, 'h0044, 'h0000);
    tick("flushhold.bubble");
    check("flushhold.valid0", 32'(EXMEMValid), 32'd0);
    tick("flushhold.capture");
    check("flushhold.rd4", 32'(EXMEMRegOp1), 32'd4);

    // Stall and flush together: one bubble, each counted once.
    bc0 = m_bc; sc0 = m_sc;
    stall_drv = 1; flush = 1; rand_ex();
    tick("stallflush");
    check("stallflush.bc", 32'(m_bc - bc0), 32'd1);
    check("stallflush.sc", 32'(m_sc - sc0), 32'd1);
    stall_drv = 0; flush = 0;

    // Saturation: keep stalling past the counter limit.
    stall_drv = 1;
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      rand_ex();
      tick("saturate");
    end
    stall_drv = 0;

    // Reset mid-hold discards a pending flush.
    mem_ready = 0; flush = 1; rand_ex();
    tick("rsthold.pend");
    flush = 0; reset = 1;
    tick("rsthold.reset");
    reset = 0; mem_ready = 1; set_ex(1, 1, 0, 1, 8, 'h0808, 'h0000);
    tick("rsthold.capture");
    check("rsthold.valid1", 32'(EXMEMValid), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_ex();
      mem_ready = ($urandom_range(0, 3) != 0);
      stall_drv = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

EX/MEM pipeline register of the term-project CPU, directly downstream of the execute stage and directly feeding `Hazard_Detection_Unit`. It captures execute-stage results each cycle and inserts a bubble when the hazard unit asserts `stall` or a branch flush arrives. It freezes when the data memory is not ready, and flushes that arrive during a freeze are held until they can take effect. Its `EXMEMMemRead` and `EXMEMRegOp1` outputs close the load-use detection loop.

## Interface
- `DATA_W`, 16: ALU result and store-data width.
- `REG_W`, 4: register-specifier width (16 registers).
- `CNT_W`, 16: statistics counter width (only with `EXMEM_STATS_EN`).

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: load-use stall from `Hazard_Detection_Unit`.
- `flush` in 1: branch-taken flush of the EX-stage instruction.
- `mem_ready` in 1: data memory can accept or complete an access this cycle.
- `ex_valid` in 1: EX-stage instruction is valid.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write` in 1 each: EX-stage control.
- `ex_reg_op1` in REG_W: destination register.
- `ex_alu_result` in DATA_W: ALU result or memory address.
- `ex_store_data` in DATA_W: store data.
- `EXMEMValid`, `EXMEMMemRead`, `EXMEMMemWrite`, `EXMEMRegWrite` out 1 each: registered control.
- `EXMEMRegOp1` out REG_W: registered destination register.
- `EXMEMAluResult`, `EXMEMStoreData` out DATA_W: registered data.
- `ex_hold` out 1: freeze IF/ID/EX this cycle (combinational, equals `!mem_ready`).
- `stall_count`, `bubble_count` out CNT_W: present only with `EXMEM_STATS_EN`.

## Operation
- State machine `RUN`/`HOLD`.
  - `RUN`→`HOLD` when `mem_ready`=0.
  - `HOLD`→`RUN` when `mem_ready`=1.
  - The state is informational; the datapath decision uses `mem_ready` directly.
- Per-edge priority, highest first:
  1. `reset`: all outputs 0, `flush_pending`=0, state `RUN`, counters 0.
  2. `mem_ready`=0: every register holds. If `flush`=1, set `flush_pending`=1.
  3. `flush` or `flush_pending`: load a bubble and clear `flush_pending`.
  4. `stall`: load a bubble.
  5. Otherwise: capture all `ex_*` inputs.
- A bubble sets all control outputs to 0, `EXMEMRegOp1`=0, and both data outputs to 0.
- `ex_valid`=0 captured normally equals a bubble: all control outputs are forced to 0 regardless of the `ex_mem_*`/`ex_reg_write` inputs.
- `stall` and `flush` together: a single bubble is loaded; each is counted once (see counters).
- `stall` while `mem_ready`=0 is ignored. The hazard unit re-evaluates after the hold.

## Timing
- Capture latency is 1 cycle: `ex_*` inputs at edge N appear on the outputs after edge N.
- Load-use: `EXMEMMemRead`=1 and a matching IDEX operand raise `stall`. The bubble is loaded at the next edge, so `EXMEMMemRead`=0 and `stall` deasserts. Exactly one bubble cycle per load-use hazard.
- `ex_hold` has zero latency from `mem_ready`.
- A flush during a hold takes effect on the first edge with `mem_ready`=1.
- Reset asserted mid-hold clears the pending flush. The first cycle after reset is in `RUN`.

## Configuration
- `EXMEM_STATS_EN` defined:
  - Adds two saturating CNT_W counters.
  - `stall_count` +1 per edge with `stall`=1 and `mem_ready`=1.
  - `bubble_count` +1 per edge on which a bubble is loaded.
  - Both saturate at all-ones and are cleared by `reset`.
- `EXMEM_STATS_EN` undefined: neither counter nor its ports exist, and behaviour is otherwise identical.

## Structure
- Shared package `cpu_pipe_pkg` holds:
  - `REG_W` and `DATA_W` defaults.
  - The `exmem_state_t` enum (`RUN`, `HOLD`).
  - The EX/MEM control bundle struct and its `EXMEM_BUBBLE` constant.
- Sub-module `sat_counter` (parameter CNT_W; ports `clk`, `reset`, `inc`, `count`). It is instantiated twice, only under `EXMEM_STATS_EN`.

## Test plan
- Reset: hold `reset` 2 cycles with nonzero inputs. Required: all outputs 0, counters 0.
- Normal capture: `ex_valid`=1, `ex_reg_write`=1, `ex_reg_op1`=3, `ex_alu_result`=16'h00A5. Required: after 1 edge, `EXMEMRegWrite`=1, `EXMEMRegOp1`=3, `EXMEMAluResult`=16'h00A5.
- Load-use through a real `Hazard_Detection_Unit`:
  - Stimulus: capture a load with `ex_mem_read`=1, `ex_reg_op1`=5, then set IDEXRegOp2=5, IDEXImmd=0.
  - Required: `stall`=1 for exactly 1 cycle; next `EXMEMMemRead`=0, `EXMEMValid`=0; `bubble_count`=1.
- Memory hold: `mem_ready`=0 for 3 cycles with changing `ex_*` inputs. Required: outputs constant, `ex_hold`=1 throughout, state `HOLD`; capture resumes on the 1st ready edge.
- Flush during hold: pulse `flush` while `mem_ready`=0, then raise `mem_ready`. Required: bubble loaded on the first ready edge; the following edge captures normally.
- Stall and flush together with `mem_ready`=1. Required: one bubble; `stall_count`+1 and `bubble_count`+1. Saturation: preload to all-ones, then assert `stall`. Required: counter stays at all-ones.
